// File: rtl/sprite_wr_pkg.sv
// Shared types and constants for the sprite RAM write-side engine.
package sprite_wr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    FILL   = 2'd2
  } state_e;

  localparam logic [1:0] REG_PTR  = 2'd0;
  localparam logic [1:0] REG_PUSH = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int BUSY_BIT     = 31;
  localparam int OVF_BIT      = 30;
  localparam int FILL_CNT_LSB = 16;
  localparam int FILL_CNT_W   = 12;

endpackage

// File: rtl/sprite_word_unpacker.sv
// Shift register that splits a packed bus word into DATA_WIDTH-bit pixels, LSB pixel first.
module sprite_word_unpacker #(
  parameter int DATA_WIDTH   = 3,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic                               advance,
  input  logic [PIX_PER_WORD*DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0]              pix,
  output logic                               last
);

  localparam int PIX_W = PIX_PER_WORD * DATA_WIDTH;
  localparam int IDX_W = $clog2(PIX_PER_WORD + 1);

  logic [PIX_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = word;
      idx_d   = '0;
    end else if (advance) begin
      shreg_d = shreg_q >> DATA_WIDTH;
      idx_d   = idx_q + 1'b1;
    end
  end

  // Pixel payload carries no reset; only the position counter does.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign pix  = shreg_q[DATA_WIDTH-1:0];
  assign last = (idx_q == IDX_W'(PIX_PER_WORD - 1));

endmodule

// File: rtl/sprite_ram_writer.sv
// MMIO front end for the sprite colour-map RAM write port: pointer, word unpack and fill engine.
// Optional build macro SPRITE_WR_SKIP_EN: zero pixels in an unpacked word are not written.
module sprite_ram_writer
  import sprite_wr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 3,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  write,
  input  logic [1:0]            addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);

  localparam int PIX_W = PIX_PER_WORD * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] colour_q, colour_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

  logic                  bus_wr, busy, load, advance, last;
  logic [DATA_WIDTH-1:0] pix;
  logic [FILL_CNT_W-1:0] fill_cnt;
  logic                  unused_wr;

  assign bus_wr    = cs & write;
  assign busy      = (state_q != IDLE);
  assign fill_cnt  = wr_data[FILL_CNT_LSB +: FILL_CNT_W];
  assign unused_wr = ^wr_data;

  sprite_word_unpacker #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_unpacker (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .word   (wr_data[PIX_W-1:0]),
    .pix    (pix),
    .last   (last)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    colour_d   = colour_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    load       = 1'b0;
    advance    = 1'b0;

    // Bus decode: commands other than CTRL are only accepted while idle.
    if (bus_wr) begin
      if (addr == REG_CTRL) begin
        if (wr_data[0]) ovf_d = 1'b0;
      end else if (busy) begin
        ovf_d = 1'b1;
      end else begin
        case (addr)
          REG_PTR:  ptr_d = wr_data[ADDR_WIDTH-1:0];
          REG_PUSH: begin
            load    = 1'b1;
            state_d = UNPACK;
          end
          REG_FILL: begin
            colour_d = wr_data[DATA_WIDTH-1:0];
            if (fill_cnt == '0 || int'(fill_cnt) > DEPTH) cnt_d = CNT_W'(DEPTH);
            else                                          cnt_d = CNT_W'(fill_cnt);
            state_d  = FILL;
          end
          default: ;
        endcase
      end
    end

    // Write engine: one RAM write per cycle, pointer wraps naturally.
    case (state_q)
      UNPACK: begin
`ifdef SPRITE_WR_SKIP_EN
        ram_we_d = (pix != '0);
`else
        ram_we_d = 1'b1;
`endif
        ram_addr_d = ptr_q;
        ram_din_d  = pix;
        ptr_d      = ptr_q + 1'b1;
        advance    = 1'b1;
        if (last) state_d = IDLE;
      end
      FILL: begin
        ram_we_d   = 1'b1;
        ram_addr_d = ptr_q;
        ram_din_d  = colour_q;
        ptr_d      = ptr_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      colour_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      colour_q   <= colour_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  always_comb begin
    rd_data                   = '0;
    rd_data[BUSY_BIT]         = busy;
    rd_data[OVF_BIT]          = ovf_q;
    rd_data[ADDR_WIDTH-1:0]   = ptr_q;
  end

  assign ram_we     = ram_we_q;
  assign ram_addr_w = ram_addr_q;
  assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed bench for sprite_ram_writer: unpack, wrap, fill, overflow and async reset.
module tb_sprite_ram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, write;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ram_we;
  logic [10:0] ram_addr_w;
  logic [2:0]  ram_din;

  int checks = 0;
  int errors = 0;

  logic [10:0] wa[$];
  logic [2:0]  wd[$];

  sprite_ram_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ram_we    (ram_we),
    .ram_addr_w(ram_addr_w),
    .ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  // RAM-side view: record every write, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wa.push_back(ram_addr_w);
      wd.push_back(ram_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; wr_data = 32'h0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (rd_data[31] === 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    int n;
    int bad;
    cs = 0; write = 0; addr = 0; wr_data = 0;
    reset = 1'b1;
    #2;
    check("rst_we", {31'b0, ram_we}, 32'h0);
    check("rst_addr", {21'b0, ram_addr_w}, 32'h0);
    check("rst_din", {29'b0, ram_din}, 32'h0);
    check("rst_rd", rd_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic unpack: pixels 0..7 to 0x010..0x017
    bus(2'd0, 32'h010);
    check("ptr_set", rd_data, 32'h010);
    clear_log();
    bus(2'd1, 32'h00FAC688);
    wait_idle(n);
    check("u1_busy_cycles", n, 8);
    check("u1_nwrites", wa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("u1_addr", {21'b0, wa[k]}, 32'h010 + k);
      check("u1_din", {29'b0, wd[k]}, k);
    end
    check("u1_rd", rd_data, 32'h018);
    check("u1_we_idle", {31'b0, ram_we}, 32'h0);
    check("u1_addr_hold", {21'b0, ram_addr_w}, 32'h017);

    // Pointer wrap during unpack
    bus(2'd0, 32'h7FE);
    clear_log();
    bus(2'd1, 32'h00FFFFFF);
    wait_idle(n);
    check("u2_nwrites", wa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("u2_addr", {21'b0, wa[k]}, (32'h7FE + k) & 32'h7FF);
      check("u2_din", {29'b0, wd[k]}, 7);
    end
    check("u2_rd", rd_data, 32'h006);

    // Fill count 0 means full depth
    bus(2'd0, 32'h123);
    clear_log();
    bus(2'd2, 32'h0000_0005);
    wait_idle(n);
    check("f0_busy_cycles", n, 2048);
    check("f0_nwrites", wa.size(), 2048);
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (wd[k] !== 3'd5 || wa[k] !== 11'((32'h123 + k) & 32'h7FF)) bad++;
    check("f0_bad_entries", bad, 0);
    check("f0_rd", rd_data, 32'h123);

    // Fill count larger than depth also means full depth
    clear_log();
    bus(2'd2, 32'h0FFF_0004);
    wait_idle(n);
    check("fbig_busy_cycles", n, 2048);
    check("fbig_nwrites", wa.size(), 2048);
    check("fbig_din0", {29'b0, wd[0]}, 4);
    check("fbig_rd", rd_data, 32'h123);

    // Short fill
    bus(2'd0, 32'h100);
    clear_log();
    bus(2'd2, 32'h0003_0002);
    wait_idle(n);
    check("f3_nwrites", wa.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("f3_addr", {21'b0, wa[k]}, 32'h100 + k);
      check("f3_din", {29'b0, wd[k]}, 2);
    end
    check("f3_rd", rd_data, 32'h103);

    // Drops while busy set overflow; CTRL is honoured while busy
    bus(2'd0, 32'h200);
    clear_log();
    bus(2'd1, 32'h00FAC688);
    bus(2'd1, 32'h00FFFFFF);
    check("ovf_set", {31'b0, rd_data[30]}, 32'h1);
    bus(2'd3, 32'h1);
    check("ovf_clr_busy", {30'b0, rd_data[31:30]}, 32'h2);
    wait_idle(n);
    check("ovf_nwrites", wa.size(), 8);
    check("ovf_din7", {29'b0, wd[7]}, 7);
    check("ovf_din3", {29'b0, wd[3]}, 3);
    check("ovf_rd", rd_data, 32'h208);
    bus(2'd1, 32'h0);
    bus(2'd0, 32'h555);
    wait_idle(n);
    check("ovf_ptr_drop", rd_data, 32'h4000_0210);
    bus(2'd3, 32'h0);
    check("ovf_ctrl0", rd_data, 32'h4000_0210);
    bus(2'd3, 32'h1);
    check("ovf_ctrl1", rd_data, 32'h0000_0210);
    bus(2'd3, 32'h0);
    check("cs_low_ignored", rd_data, 32'h0000_0210);

    // cs low ignores a write
    cs = 1'b0; write = 1'b1; addr = 2'd0; wr_data = 32'h3FF;
    @(posedge clk); #1;
    write = 1'b0;
    check("cs0_ptr", rd_data, 32'h0000_0210);

    // Async reset at the 4th pixel of an unpack
    bus(2'd0, 32'h040);
    clear_log();
    bus(2'd1, 32'h00FAC688);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_din", {29'b0, ram_din}, 3);
    check("pre_rst_addr", {21'b0, ram_addr_w}, 32'h043);
    #2 reset = 1'b1;
    #1;
    check("arst_we", {31'b0, ram_we}, 32'h0);
    check("arst_addr", {21'b0, ram_addr_w}, 32'h0);
    check("arst_din", {29'b0, ram_din}, 32'h0);
    check("arst_logged", wa.size(), 3);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_log();
    repeat (12) begin @(posedge clk); #1; end
    check("post_rst_rd", rd_data, 32'h0);
    check("post_rst_nwrites", wa.size(), 0);

    // Transparent-key behaviour
    bus(2'd0, 32'h000);
    clear_log();
    bus(2'd1, 32'h0000_0008);
    wait_idle(n);
`ifdef SPRITE_WR_SKIP_EN
    check("skip_nwrites", wa.size(), 1);
    check("skip_addr", {21'b0, wa[0]}, 32'h001);
    check("skip_din", {29'b0, wd[0]}, 1);
`else
    check("noskip_nwrites", wa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("noskip_addr", {21'b0, wa[k]}, k);
      check("noskip_din", {29'b0, wd[k]}, (k == 1) ? 1 : 0);
    end
`endif
    check("skip_rd", rd_data, 32'h008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
